pwm_multichannel: RTL and testbench
===================================

# pwm_multichannel

Parametrised multi-channel PWM peripheral, the successor to the single-duty PWM block in the TinyTapeout top. It holds per-channel output-enable, PWM-enable and duty registers plus a shared clock prescaler, all written over a byte-wide register port driven by the SPI peripheral. Duty and prescaler writes are double-buffered and take effect only at a period boundary, so outputs never glitch. It drives `NUM_CH` output pins.

## Interface
- `NUM_CH`, default 16: channel count. Legal values are 8, 16, 24 and 32.
- `clk` input 1: the single clock for the block.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `wr_en` input 1: write strobe. Sampled on the `clk` rising edge.
- `wr_addr` input 7: register address.
- `wr_data` input 8: write data.
- `out` output `NUM_CH`: registered PWM outputs.
- `period_start` output 1: one-cycle pulse on the first clock of every PWM period.

## Operation
- **Register map** (7-bit addresses):
  - 0x00–0x03 `en_out` byte k → channels 8k..8k+7.
  - 0x04–0x07 `en_pwm` byte k.
  - 0x08 `presc`.
  - 0x09 `mode`.
  - 0x10+ch `duty[ch]`.
- **Ignored writes:** writes to unmapped addresses, and to bytes or channels at or above `NUM_CH`, are ignored.
- **Effect of writes:**
  - `en_out` and `en_pwm` are live: they affect `out` immediately.
  - `duty` and `presc` writes go to pending registers. The pending values copy into the active registers at the period wrap.
- **Timebase:**
  - The prescaler counts 0..`presc_act`; a tick is generated when it reaches `presc_act`, after which it returns to 0.
  - The 8-bit counter `cnt` advances once per tick.
  - Edge mode: `cnt` runs 0..254, then wraps to 0. The period is 255 ticks.
- **Output function:** `out[ch] = en_out[ch] & (en_pwm[ch] ? pwm[ch] : 1)`, where `pwm[ch] = (duty_act[ch] == 8'hFF) | (cnt < duty_act[ch])`.
  - Duty 0 gives a constant-low output.
  - Duty 255 gives a constant-high output.
  - Otherwise the channel is high for `duty` ticks out of 255.
- **Wrap event:** the wrap occurs on the tick where `cnt` returns to 0. In the same cycle, all pending values copy to active and `period_start` asserts.
- **Write on the wrap cycle:** a write in the same cycle as the wrap lands in pending only. The active register takes the pre-write pending value, and the new value applies at the following wrap.
- **Reset mid-operation:** all state clears asynchronously.

## Timing
- **Reset values:** `out` = 0, `period_start` = 0. All enables, duties (pending and active), `presc` and `mode` are 0. Both counters are 0.
- **Write latency:** a write is sampled at edge E0. The register updates at E0, and `out` reflects an `en_*` change at E1 (one cycle of latency).
- **Duty/prescaler latency:** the new value first affects `out` on the cycle after the next wrap.
- **Period length:** 255·(`presc`+1) clocks in edge mode. After reset, the first `period_start` pulse occurs at clock 255·(`presc`+1).
- **Output registering:** `out` is a flop stage computed from current `cnt`. The output has no combinational path from `wr_*`.

## Configuration
- **Macro:** `PWM_CENTER_ALIGNED_EN`.
- **Defined:** `mode[0]` = 1 selects centre-aligned counting.
  - `cnt` counts up 0..254, then down 253..1, then back to 0. The period is 508 ticks.
  - `out` uses the same compare, so pulses are centred on `cnt` = 0.
  - The wrap (pending→active copy and `period_start`) happens only at `cnt` = 0.
  - A change to `mode` is itself pending and applies at the wrap.
- **Not defined:** address 0x09 is unmapped, `mode` reads as 0, and the block is edge-aligned only.

## Structure
- **Package `pwm_mc_pkg`:**
  - Address constants: `ADDR_EN_OUT`, `ADDR_EN_PWM`, `ADDR_PRESC`, `ADDR_MODE`, `ADDR_DUTY_BASE`.
  - `CNT_MAX` = 254.
  - `MAX_CH` = 32.
- **Sub-module `pwm_timebase`:** contains the prescaler, the up/down counter, and wrap/`period_start` generation. It outputs `cnt` and `wrap`.
- **Top:** the register file and the per-channel compare live in the top via a generate loop.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-period with all channels running → `out` = 0 asynchronously. After release, all registers read as reset values and `out` stays 0.
- **Basic PWM:** `NUM_CH` = 16, `presc` = 0, `en_out[0]` = 0xFF, `en_pwm[0]` = 0x01, `duty[0]` = 0x80. Expected:
  - `out[0]` is high for 128 of every 255 clocks.
  - `out[7:1]` is constant 1.
  - `out[15:8]` is 0.
- **Duty extremes:** `duty` = 0x00 → constant 0. `duty` = 0xFF → constant 1 with no low cycle across a wrap.
- **Double buffering:** active duty is 0x80. Write 0x40 at `cnt` = 20 → the current period still has 128 high clocks, the next period has 64. A write landing on the wrap cycle is deferred one period.
- **Prescaler:** `presc` = 3 → `period_start` pulses every 1020 clocks and `duty` 0x80 gives 512 high clocks.
- **Centre-aligned** (`PWM_CENTER_ALIGNED_EN`): `mode` = 1, `duty` = 10 → `out` is high for 19 ticks centred on `cnt` = 0, and `period_start` occurs every 508 ticks.

Source files
------------

// File: rtl/pwm_mc_pkg.sv
// Shared constants and the write-request bundle for the multi-channel PWM block.
package pwm_mc_pkg;
  localparam logic [6:0] ADDR_EN_OUT    = 7'h00;
  localparam logic [6:0] ADDR_EN_PWM    = 7'h04;
  localparam logic [6:0] ADDR_PRESC     = 7'h08;
  localparam logic [6:0] ADDR_MODE      = 7'h09;
  localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;
  localparam logic [7:0] CNT_MAX        = 8'd254;
  localparam int         MAX_CH         = 32;

  typedef struct packed {
    logic       en;
    logic [6:0] addr;
    logic [7:0] data;
  } wr_req_t;
endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit period counter (edge or centre-aligned) and wrap/period_start generation.
module pwm_timebase
  import pwm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] presc,
  input  logic       center,
  output logic [7:0] cnt,
  output logic       wrap,
  output logic       period_start
);
  logic [7:0] pcnt;
  logic       down;
  logic       tick;

  assign tick = (pcnt == presc);
  // Centre mode only wraps coming down through 1 -> 0; edge mode wraps at the top.
  assign wrap = tick & (center ? (down & (cnt == 8'd1)) : (cnt == CNT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt         <= '0;
      cnt          <= '0;
      down         <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      pcnt         <= tick ? 8'd0 : pcnt + 8'd1;
      if (tick) begin
        if (wrap) begin
          cnt  <= '0;
          down <= 1'b0;
        end else if (down) begin
          cnt <= cnt - 8'd1;
        end else if (center && cnt == CNT_MAX) begin
          cnt  <= CNT_MAX - 8'd1;
          down <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: byte-wide register file, double-buffered duty/prescaler, registered outputs.
// Optional centre-aligned counting is built when PWM_CENTER_ALIGNED_EN is defined.
module pwm_multichannel
  import pwm_mc_pkg::*;
#(
  parameter int NUM_CH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);
  localparam int NB = NUM_CH / 8;

  wr_req_t                  req;
  logic [NB-1:0][7:0]       en_out_q, en_pwm_q;
  logic [NUM_CH-1:0][7:0]   duty_pend, duty_act;
  logic [7:0]               presc_pend, presc_act;
  logic                     center_act;
  logic [7:0]               cnt;
  logic                     wrap;
  logic [NUM_CH-1:0]        out_d;

  assign req = '{en: wr_en, addr: wr_addr, data: wr_data};

  pwm_timebase u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .presc        (presc_act),
    .center       (center_act),
    .cnt          (cnt),
    .wrap         (wrap),
    .period_start (period_start)
  );

  // Pending copies are taken before this cycle's write, so a write on the wrap waits a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_q   <= '0;
      en_pwm_q   <= '0;
      duty_pend  <= '0;
      duty_act   <= '0;
      presc_pend <= '0;
      presc_act  <= '0;
    end else begin
      if (wrap) begin
        duty_act  <= duty_pend;
        presc_act <= presc_pend;
      end
      if (req.en) begin
        for (int b = 0; b < NB; b++) begin
          if (req.addr == ADDR_EN_OUT + 7'(b)) en_out_q[b] <= req.data;
          if (req.addr == ADDR_EN_PWM + 7'(b)) en_pwm_q[b] <= req.data;
        end
        if (req.addr == ADDR_PRESC) presc_pend <= req.data;
        for (int ch = 0; ch < NUM_CH; ch++)
          if (req.addr == ADDR_DUTY_BASE + 7'(ch)) duty_pend[ch] <= req.data;
      end
    end
  end

`ifdef PWM_CENTER_ALIGNED_EN
  logic center_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      center_pend <= 1'b0;
      center_act  <= 1'b0;
    end else begin
      if (wrap) center_act <= center_pend;
      if (req.en && req.addr == ADDR_MODE) center_pend <= req.data[0];
    end
  end
`else
  assign center_act = 1'b0;
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic pwm;
    assign pwm       = (duty_act[ch] == 8'hFF) | (cnt < duty_act[ch]);
    assign out_d[ch] = en_out_q[ch/8][ch%8] & (~en_pwm_q[ch/8][ch%8] | pwm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= out_d;
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboard bench: a period-position model predicts out/period_start every clock.
module tb_pwm_multichannel;
  localparam int NUM_CH = 16;
  localparam int NB     = NUM_CH / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [6:0]        wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic [NUM_CH-1:0] out;
  logic              period_start;

  pwm_multichannel #(.NUM_CH(NUM_CH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endfunction

  // Model: k = clock position inside the current period; everything else follows from it.
  int                k;
  int                p_act, p_pend;
  bit                c_act, c_pend;
  int                duty_act[NUM_CH], duty_pend[NUM_CH];
  bit [NUM_CH-1:0]   m_en_out, m_en_pwm;

  typedef struct { logic [NUM_CH-1:0] o; logic ps; } exp_t;
  exp_t exp_q[$];

  function automatic int period_len();
    return (c_act ? 508 : 255) * (p_act + 1);
  endfunction

  function automatic int model_cnt();
    int i = k / (p_act + 1);
    if (c_act && i > 254) return 508 - i;
    return i;
  endfunction

  function automatic logic [NUM_CH-1:0] model_out();
    logic [NUM_CH-1:0] r;
    int c = model_cnt();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit hi = (duty_act[ch] == 255) || (c < duty_act[ch]);
      r[ch] = m_en_out[ch] && (!m_en_pwm[ch] || hi);
    end
    return r;
  endfunction

  function automatic void model_reset();
    k = 0; p_act = 0; p_pend = 0; c_act = 0; c_pend = 0;
    m_en_out = '0; m_en_pwm = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin duty_act[ch] = 0; duty_pend[ch] = 0; end
    exp_q.delete();
  endfunction

  function automatic void model_write(int a, int d);
    if (a < 4 && a < NB) m_en_out[8*a +: 8] = 8'(d);
    else if (a >= 4 && a < 8 && a - 4 < NB) m_en_pwm[8*(a-4) +: 8] = 8'(d);
    else if (a == 8) p_pend = d;
`ifdef PWM_CENTER_ALIGNED_EN
    else if (a == 9) c_pend = d[0];
`endif
    else if (a >= 16 && a < 16 + NUM_CH) duty_pend[a-16] = d;
  endfunction

  initial begin
    exp_t e;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        e.o  = model_out();
        e.ps = (k == period_len() - 1);
        exp_q.push_back(e);
        if (e.ps) begin
          k = 0; p_act = p_pend; c_act = c_pend;
          duty_act = duty_pend;
        end else k++;
        if (wr_en) model_write(int'(wr_addr), int'(wr_data));
      end
    end
  end

  // Monitor: one expected entry per clock, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", 64'(out), 64'(e.o));
        check("period_start", 64'(period_start), 64'(e.ps));
      end
    end
  end

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 7'(a); wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_ps(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (period_start) return;
    end
    checks++;
    $display("FAIL ps_timeout: no period_start within %0d clocks", limit);
  endtask

  task automatic ps_interval(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!period_start && n < 5000);
  endtask

  task automatic count_cycles(input int ch, input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      hi += int'(out[ch]);
      @(negedge clk);
    end
  endtask

  initial begin
    int hi, n;
    repeat (3) @(negedge clk);
    check("reset_out", 64'(out), 64'd0);
    check("reset_ps", 64'(period_start), 64'd0);
    rst_n = 1'b1;

    // Basic PWM on channel 0, others forced high/low by enables
    wr(8'h00, 8'hFF); wr(8'h04, 8'h01); wr(8'h10, 8'h80);
    wait_ps(600); wait_ps(600);
    count_cycles(0, 255, hi);
    check("basic_high", 64'(hi), 64'd128);
    check("basic_out7_1", 64'(out[7:1]), 64'h7F);
    check("basic_out15_8", 64'(out[15:8]), 64'h00);

    // Double buffering: mid-period write, then a write landing on the wrap
    for (int i = 0; i < 600 && model_cnt() != 20; i++) @(negedge clk);
    wr(8'h10, 8'h40);
    for (int i = 0; i < 600 && k != period_len() - 1; i++) @(negedge clk);
    wr_en = 1'b1; wr_addr = 7'h10; wr_data = 8'h20;
    @(negedge clk);
    wr_en = 1'b0;
    count_cycles(0, 255, hi);
    check("dbuf_next", 64'(hi), 64'd64);
    count_cycles(0, 255, hi);
    check("dbuf_wrapwrite", 64'(hi), 64'd32);

    // Duty extremes
    wr(8'h10, 8'h00); wait_ps(600); wait_ps(600);
    count_cycles(0, 255, hi);
    check("duty_zero", 64'(hi), 64'd0);
    wr(8'h10, 8'hFF); wait_ps(600); wait_ps(600);
    count_cycles(0, 510, hi);
    check("duty_full", 64'(hi), 64'd510);

    // Prescaler
    wr(8'h10, 8'h80); wr(8'h08, 8'd3);
    wait_ps(600); wait_ps(2100);
    ps_interval(n);
    check("presc_period", 64'(n), 64'd1020);
    count_cycles(0, 1020, hi);
    check("presc_high", 64'(hi), 64'd512);
    wr(8'h08, 8'd0); wait_ps(2100);

`ifdef PWM_CENTER_ALIGNED_EN
    wr(8'h09, 8'h01); wr(8'h10, 8'd10);
    wait_ps(600); wait_ps(1100);
    ps_interval(n);
    check("center_period", 64'(n), 64'd508);
    count_cycles(0, 508, hi);
    check("center_high", 64'(hi), 64'd19);
    wr(8'h09, 8'h00); wait_ps(1100);
`endif

    // Randomized writes, including unmapped and out-of-range addresses
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        wr_en   = 1'b1;
        wr_addr = 7'($urandom_range(0, 63));
        wr_data = (wr_addr == 7'h08) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      end else wr_en = 1'b0;
    end
    @(negedge clk);
    wr_en = 1'b0;

    // Async reset mid-period with channels running
    wr(8'h00, 8'hFF); wr(8'h01, 8'hFF); wr(8'h04, 8'h00); wr(8'h05, 8'h00);
    repeat (5) @(negedge clk);
    check("pre_reset_out", 64'(out), 64'hFFFF);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", 64'(out), 64'd0);
    check("async_reset_ps", 64'(period_start), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("post_reset_out", 64'(out), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
